// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
//
// Pipelined WIDTH-bit subtractor computing a - b. The operands are split into
// STAGES chunks of CW = WIDTH/STAGES bits. Stage k subtracts chunk k (LSB chunk
// first) and registers its borrow-out for stage k+1. The last stage also
// derives the flags, applies the per-transaction mode, and loads the output
// registers. Latency is STAGES cycles and throughput is one result per cycle.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   a, b       minuend / subtrahend (WIDTH bits)
//   mode       00 wrap, 01 unsigned saturate, 10 signed saturate, 11 wrap
//   out_valid  result valid
//   out_ready  downstream accepts result
//   diff       result after mode handling
//   borrow     unsigned borrow-out (a < b)
//   ovf        signed overflow of a - b
//   zero       raw (pre-saturation) difference is zero
module pipelined_subtractor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SMin = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMax = ~SMin;

  // Inputs to each stage. Element 0 comes from the ports; element k+1 comes
  // from the registers of stage k.
  logic             w_s_valid [STAGES];
  logic [WIDTH-1:0] w_s_a     [STAGES];
  logic [WIDTH-1:0] w_s_b     [STAGES];
  logic [1:0]       w_s_mode  [STAGES];
  logic [WIDTH-1:0] w_s_raw   [STAGES];
  logic             w_s_bin   [STAGES];

  logic r_out_valid;
  logic w_advance;

  // The whole pipeline stalls only when a result is waiting and not taken.
  assign w_advance = !(r_out_valid && !out_ready);
  assign in_ready  = rst_n && w_advance;

  assign w_s_valid[0] = in_valid;
  assign w_s_a[0]     = a;
  assign w_s_b[0]     = b;
  assign w_s_mode[0]  = mode;
  assign w_s_raw[0]   = '0;
  assign w_s_bin[0]   = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      w_sub;
    logic [WIDTH-1:0] w_raw;

    // The extra MSB of w_sub captures the chunk's borrow-out.
    always_comb begin
      w_sub = {1'b0, w_s_a[k][k*CW +: CW]} - {1'b0, w_s_b[k][k*CW +: CW]}
              - {{CW{1'b0}}, w_s_bin[k]};
      w_raw = w_s_raw[k];
      w_raw[k*CW +: CW] = w_sub[CW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic             r_valid;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [1:0]       r_mode;
      logic [WIDTH-1:0] r_raw;
      logic             r_bout;

      // Only the valid bit needs clearing; data in an invalid slot is ignored.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
        end else if (w_advance) begin
          r_valid <= w_s_valid[k];
        end
      end

      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_a    <= w_s_a[k];
          r_b    <= w_s_b[k];
          r_mode <= w_s_mode[k];
          r_raw  <= w_raw;
          r_bout <= w_sub[CW];
        end
      end

      assign w_s_valid[k+1] = r_valid;
      assign w_s_a[k+1]     = r_a;
      assign w_s_b[k+1]     = r_b;
      assign w_s_mode[k+1]  = r_mode;
      assign w_s_raw[k+1]   = r_raw;
      assign w_s_bin[k+1]   = r_bout;
    end else begin : g_last
      logic             w_borrow;
      logic             w_ovf;
      logic             w_zero;
      logic             w_a_msb;
      logic [WIDTH-1:0] w_diff;
      logic [WIDTH-1:0] r_diff;
      logic             r_borrow;
      logic             r_ovf;
      logic             r_zero;

      always_comb begin
        w_a_msb  = w_s_a[k][WIDTH-1];
        w_borrow = w_sub[CW];
        w_ovf    = (w_a_msb != w_s_b[k][WIDTH-1]) && (w_raw[WIDTH-1] != w_a_msb);
        w_zero   = (w_raw == '0);
        w_diff   = w_raw;
        case (w_s_mode[k])
          2'b01: begin
            if (w_borrow) w_diff = '0;
          end
          2'b10: begin
            // Overflow direction follows the minuend sign.
            if (w_ovf) w_diff = w_a_msb ? SMin : SMax;
          end
          default: w_diff = w_raw;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
          r_diff      <= '0;
          r_borrow    <= 1'b0;
          r_ovf       <= 1'b0;
          r_zero      <= 1'b0;
        end else if (w_advance) begin
          r_out_valid <= w_s_valid[k];
          r_diff      <= w_diff;
          r_borrow    <= w_borrow;
          r_ovf       <= w_ovf;
          r_zero      <= w_zero;
        end
      end

      assign diff   = r_diff;
      assign borrow = r_borrow;
      assign ovf    = r_ovf;
      assign zero   = r_zero;
    end
  end

  assign out_valid = r_out_valid;

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Parametrised, pipelined WIDTH-bit subtractor computing a − b.
- Operands are split into STAGES equal chunks; each pipeline stage subtracts one chunk, LSB chunk first, and passes the borrow to the next stage.
- Supports a per-transaction wrap, unsigned-saturate or signed-saturate mode, with valid/ready handshakes on input and output.
- Successor to the combinational parameterised subtractor, for datapaths where a full-width borrow chain misses timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- mode  input  2  result mode: 00 wrap, 01 unsigned saturate, 10 signed saturate, 11 treated as wrap.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- diff  output  WIDTH  result after mode handling.
- borrow  output  1  unsigned borrow-out (a < b unsigned).
- ovf  output  1  signed overflow of two's-complement a − b.
- zero  output  1  raw (pre-saturation) difference == 0.

Behaviour:
- Reset (already decided): one clock, clk; reset rst_n is synchronous and active-low.
  - While rst_n = 0 at a posedge: every stage valid bit clears, out_valid = 0, diff = 0, borrow = 0, ovf = 0, zero = 0.
  - in_ready = 0 during reset cycles.
  - Reset mid-operation discards all in-flight transactions; none are emitted afterwards.
- Handshake:
  - advance = !(out_valid && !out_ready).
  - in_ready = advance.
  - A transaction is accepted on a posedge with in_valid && in_ready.
  - When advance = 0, every stage and the output registers hold; nothing is lost or duplicated.
  - Results emerge in acceptance order.
- Latency and throughput:
  - An accepted transaction appears with out_valid = 1 exactly STAGES posedges after acceptance when there is no backpressure.
  - Throughput is 1 per cycle.
  - Bubbles (in_valid = 0) propagate as invalid slots.
- Stage k (0..STAGES−1):
  - Computes chunk k: d_k = a_k − b_k − bin_k over CW bits.
  - bin_0 = 0; bout_k = borrow out of that chunk subtraction; bin_{k+1} = bout_k, registered.
  - Unprocessed higher chunks of a and b travel with the transaction in the stage registers, as do mode and the completed lower diff chunks.
- Final stage, combinational before the output register:
  - raw = concatenated chunks; borrow = bout_{STAGES−1}.
  - ovf = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]).
  - zero = (raw == 0).
- Mode handling, selecting diff:
  - 00/11: diff = raw.
  - 01: diff = 0 if borrow, else raw.
  - 10, ovf = 1 and a[MSB] = 1: diff = 1 followed by zeros (most negative value).
  - 10, ovf = 1 and a[MSB] = 0: diff = 0 followed by ones (most positive value).
  - 10, ovf = 0: diff = raw.
- Flags borrow, ovf and zero are always reported regardless of mode.
- Outputs are registered and stable while out_valid && !out_ready.
- STAGES = 1 degenerates to a single registered full-width subtract with latency 1.
- Simultaneous accept and emit in the same cycle is legal at full rate.

Test Plan:
1. WIDTH=8, STAGES=2, mode=00, a=0x10, b=0x01 (borrow crosses the chunk boundary) → after 2 cycles: diff=0x0F, borrow=0, ovf=0, zero=0.
2. a=0x01, b=0x02:
   - mode=00 → diff=0xFF, borrow=1.
   - mode=01 → diff=0x00, borrow=1, zero=0.
3. a=0x80, b=0x01:
   - mode=10 → diff=0x80, ovf=1.
   - mode=00 → diff=0x7F, ovf=1.
   - a=0x7F, b=0xFF, mode=10 → diff=0x7F, ovf=1, borrow=1.
4. a=b=0x5A, mode=01 → diff=0x00, zero=1, borrow=0, ovf=0.
5. Backpressure: stream 6 operand pairs back-to-back; hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 and outputs frozen during the hold; all 6 results later appear in order, none dropped or duplicated.
6. Reset mid-flight: accept 2 transactions, assert rst_n=0 for 1 cycle → out_valid=0 and all outputs 0 the next cycle; neither transaction ever appears; a new op issued after reset has normal latency 2.
